// File: rtl/regfile_bypass.sv
// Two-read, two-write register file with optional write-to-read forwarding,
// per-register written flags and a saturating update counter.
module regfile_bypass #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NREG     = 15,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned RSP_IDX  = 4,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] srcA_i,
    input  logic [ADDR_W-1:0] srcB_i,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    input  logic              wenE_i,
    input  logic [ADDR_W-1:0] dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic              wenM_i,
    input  logic [ADDR_W-1:0] dstM_i,
    input  logic [DATA_W-1:0] valM_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic [NREG-1:0]   written_o,
    output logic [31:0]       wr_cnt_o
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   written_q;
    logic [31:0]       cnt_q;

    logic            commit_e, commit_m, same_dst;
    logic [NREG-1:0] hit_e, hit_m;
    logic [1:0]      n_upd;
    logic [32:0]     cnt_sum;

    // Commit already excludes reset, so forwarding is suppressed during reset too.
    assign commit_e = wenE_i && (32'(dstE_i) < NREG) && !rst_i;
    assign commit_m = wenM_i && (32'(dstM_i) < NREG) && !rst_i;
    assign same_dst = (dstE_i == dstM_i);

    always_comb begin
        hit_e = '0;
        hit_m = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            hit_m[i] = commit_m && (32'(dstM_i) == i);
            hit_e[i] = commit_e && (32'(dstE_i) == i) && !hit_m[i];
        end
    end

    always_comb begin
        n_upd = 2'(commit_e) + 2'(commit_m);
        if (commit_e && commit_m && same_dst) begin
            n_upd = 2'd1;
        end
        cnt_sum = {1'b0, cnt_q} + 33'(n_upd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
            end
            written_q <= '0;
            cnt_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (hit_m[i]) begin
                    regs_q[i] <= valM_i;
                end else if (hit_e[i]) begin
                    regs_q[i] <= valE_i;
                end
            end
            written_q <= written_q | hit_e | hit_m;
            cnt_q     <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

    always_comb begin
        valA_o     = '0;
        valB_o     = '0;
        dbg_data_o = '0;
        if (32'(srcA_i) < NREG) begin
            if (BYPASS && commit_m && dstM_i == srcA_i) begin
                valA_o = valM_i;
            end else if (BYPASS && commit_e && dstE_i == srcA_i) begin
                valA_o = valE_i;
            end else begin
                valA_o = regs_q[srcA_i];
            end
        end
        if (32'(srcB_i) < NREG) begin
            if (BYPASS && commit_m && dstM_i == srcB_i) begin
                valB_o = valM_i;
            end else if (BYPASS && commit_e && dstE_i == srcB_i) begin
                valB_o = valE_i;
            end else begin
                valB_o = regs_q[srcB_i];
            end
        end
        if (32'(dbg_addr_i) < NREG) begin
            dbg_data_o = regs_q[dbg_addr_i];
        end
    end

    assign written_o = written_q;
    assign wr_cnt_o  = cnt_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass (BYPASS=1, RSP_INIT=0x100).
module tb_regfile_bypass;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  srcA_i, srcB_i, dstE_i, dstM_i, dbg_addr_i;
    logic [63:0] valA_o, valB_o, valE_i, valM_i, dbg_data_o;
    logic        wenE_i, wenM_i;
    logic [14:0] written_o;
    logic [31:0] wr_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_bypass #(
        .DATA_W(64), .NREG(15), .ADDR_W(4), .RSP_IDX(4),
        .RSP_INIT(64'h100), .BYPASS(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .srcA_i(srcA_i), .srcB_i(srcB_i), .valA_o(valA_o), .valB_o(valB_o),
        .wenE_i(wenE_i), .dstE_i(dstE_i), .valE_i(valE_i),
        .wenM_i(wenM_i), .dstM_i(dstM_i), .valM_i(valM_i),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o),
        .written_o(written_o), .wr_cnt_o(wr_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_writes();
        wenE_i = 1'b0; wenM_i = 1'b0;
        dstE_i = 4'hF; dstM_i = 4'hF;
        valE_i = '0;   valM_i = '0;
    endtask

    initial begin
        rst_i = 1'b1;
        srcA_i = '0; srcB_i = '0; dbg_addr_i = '0;
        idle_writes();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;

        // Reset state over every index, including the null one.
        for (int i = 0; i < 16; i++) begin
            dbg_addr_i = 4'(i);
            #1;
            chk($sformatf("reset_reg%0d", i), dbg_data_o, (i == 4) ? 64'h100 : 64'h0);
        end
        chk("reset_written", 64'(written_o), 64'h0);
        chk("reset_cnt", 64'(wr_cnt_o), 64'h0);

        // Single E write with same-cycle forward; debug port never forwards.
        @(negedge clk);
        wenE_i = 1'b1; dstE_i = 4'd2; valE_i = 64'hAA; srcA_i = 4'd2; dbg_addr_i = 4'd2;
        #1;
        chk("e_fwd_valA", valA_o, 64'hAA);
        chk("e_dbg_nofwd", dbg_data_o, 64'h0);
        @(posedge clk); #1;
        idle_writes();
        #1;
        chk("e_stored_valA", valA_o, 64'hAA);
        chk("e_cnt", 64'(wr_cnt_o), 64'd1);
        chk("e_written", 64'(written_o), 64'h0004);

        // Same-index collision: M wins, counts once.
        @(negedge clk);
        wenE_i = 1'b1; dstE_i = 4'd4; valE_i = 64'h8;
        wenM_i = 1'b1; dstM_i = 4'd4; valM_i = 64'h55; srcB_i = 4'd4;
        #1;
        chk("coll_fwd_valB", valB_o, 64'h55);
        @(posedge clk); #1;
        idle_writes();
        #1;
        chk("coll_stored_valB", valB_o, 64'h55);
        chk("coll_cnt", 64'(wr_cnt_o), 64'd2);
        chk("coll_written", 64'(written_o), 64'h0014);

        // Two distinct targets in one cycle.
        @(negedge clk);
        wenE_i = 1'b1; dstE_i = 4'd3; valE_i = 64'h1;
        wenM_i = 1'b1; dstM_i = 4'd5; valM_i = 64'h2;
        srcA_i = 4'd3; srcB_i = 4'd5;
        #1;
        chk("dual_fwd_valA", valA_o, 64'h1);
        chk("dual_fwd_valB", valB_o, 64'h2);
        @(posedge clk); #1;
        idle_writes();
        #1;
        chk("dual_stored_valA", valA_o, 64'h1);
        chk("dual_stored_valB", valB_o, 64'h2);
        chk("dual_cnt", 64'(wr_cnt_o), 64'd4);
        chk("dual_written", 64'(written_o), 64'h003C);

        // Null-index write is discarded; disabled write with valid index too.
        @(negedge clk);
        wenE_i = 1'b1; dstE_i = 4'hF; valE_i = 64'hDEAD;
        wenM_i = 1'b0; dstM_i = 4'd6; valM_i = 64'h123;
        srcA_i = 4'hF; srcB_i = 4'd6;
        #1;
        chk("null_valA", valA_o, 64'h0);
        chk("nowen_valB", valB_o, 64'h0);
        @(posedge clk); #1;
        idle_writes();
        #1;
        chk("null_valA_after", valA_o, 64'h0);
        chk("nowen_valB_after", valB_o, 64'h0);
        chk("null_cnt", 64'(wr_cnt_o), 64'd4);
        chk("null_written", 64'(written_o), 64'h003C);

        // Write during reset: discarded and not forwarded.
        @(negedge clk);
        rst_i = 1'b1;
        wenE_i = 1'b1; dstE_i = 4'd1; valE_i = 64'h7;
        wenM_i = 1'b1; dstM_i = 4'd2; valM_i = 64'h99;
        srcA_i = 4'd1; srcB_i = 4'd2;
        #1;
        chk("rst_valA", valA_o, 64'h0);
        chk("rst_nofwd_valB", valB_o, 64'hAA);
        @(posedge clk); #1;
        rst_i = 1'b0;
        idle_writes();
        #1;
        chk("rst_valA_after", valA_o, 64'h0);
        chk("rst_valB_after", valB_o, 64'h0);
        dbg_addr_i = 4'd4;
        #1;
        chk("rst_rsp", dbg_data_o, 64'h100);
        chk("rst_cnt", 64'(wr_cnt_o), 64'd0);
        chk("rst_written", 64'(written_o), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
